// File: rtl/lsu_mem_stage.sv
// RV32I load/store stage: byte/half/word accesses over a req/gnt/rvalid data bus.
// Optional watchdog on gnt/rvalid is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        store_q, err_q;
  logic        legal_f3, misaligned, bad_access;
  logic        timeout, abort;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext, lane_wdata;
  logic [3:0]  lane_strb;

  always_comb begin
    legal_f3   = is_store ? (!funct3[2] && funct3[1:0] != 2'b11)
                          : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    bad_access = !legal_f3 || misaligned;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] to_cnt;

  // Any state change clears the counter, which covers entry to both REQ and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                to_cnt <= '0;
    else if (state_nx != state)             to_cnt <= '0;
    else if (state == REQ || state == RESP) to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == REQ || state == RESP) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A handshake landing in the same cycle as the watchdog still wins.
  assign abort = timeout && !((state == REQ && mem_gnt) || (state == RESP && mem_rvalid));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = bad_access ? DONE : REQ;
      REQ: begin
        if (mem_gnt)    state_nx = store_q ? DONE : RESP;
        else if (abort) state_nx = DONE;
      end
      RESP: if (mem_rvalid || abort) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_v = '0;
    case (addr_q[1:0])
      2'd0: byte_v = mem_rdata[7:0];
      2'd1: byte_v = mem_rdata[15:8];
      2'd2: byte_v = mem_rdata[23:16];
      2'd3: byte_v = mem_rdata[31:24];
      default: byte_v = '0;
    endcase
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_ext = {{16{half_v[15]}}, half_v};
      3'b100:  load_ext = {24'h0, byte_v};
      3'b101:  load_ext = {16'h0, half_v};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        lane_strb  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_strb  = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        funct3_q <= funct3;
        store_q  <= is_store;
        err_q    <= bad_access;
        rdata_q  <= '0;
      end
      if (state == RESP && mem_rvalid) rdata_q <= load_ext;
      if (abort) err_q <= 1'b1;
    end
  end

  always_comb begin
    busy      = (state == REQ) || (state == RESP) || (state == IDLE && start);
    done      = (state == DONE);
    rdata     = (state == DONE) ? rdata_q : '0;
    err       = (state == DONE) && err_q;
    mem_req   = (state == REQ);
    mem_we    = (state == REQ) && store_q;
    mem_addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : '0;
    mem_wstrb = (state == REQ && store_q) ? lane_strb : '0;
    mem_wdata = (state == REQ && store_q) ? lane_wdata : '0;
  end

endmodule
